nbbpu_mc: RTL and testbench



---
 rtl/nbbpu_pkg.sv | 49 ++++
 rtl/nbbpu_regfile.sv | 32 +++
 rtl/nbbpu_mc.sv | 189 ++++++++++++++++++
 tb/tb_nbbpu_mc.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nbbpu_pkg.sv
// nbbpu_pkg: opcode and state enums, instruction field positions and small decode
// helpers shared by the nbbpu_mc core and its register file.
package nbbpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_IOR = 4'h3,
    OP_XOR = 4'h4,
    OP_SHR = 4'h5,
    OP_SHL = 4'h6,
    OP_CMP = 4'h7,
    OP_JMP = 4'h8,
    OP_BRZ = 4'h9,
    OP_BRN = 4'hA,
    OP_RES = 4'hB,
    OP_LOD = 4'hC,
    OP_STR = 4'hD,
    OP_SEL = 4'hE,
    OP_SEU = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_MEMORY  = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;
  localparam int OP_LSB  = 12;
  localparam int X_LSB   = 8;
  localparam int Y_LSB   = 4;
  localparam int Z_LSB   = 0;
  localparam int IMM_LSB = 4;

  // Instructions that write their z register during EXECUTE (LOD writes later, in MEMORY).
  function automatic logic writes_reg(input opcode_e op);
    return !(op inside {OP_BRZ, OP_BRN, OP_RES, OP_LOD, OP_STR});
  endfunction

  function automatic logic is_mem_op(input opcode_e op);
    return op inside {OP_LOD, OP_STR};
  endfunction

endpackage

// File: rtl/nbbpu_regfile.sv
// nbbpu_regfile: 16 x DATA_WIDTH registers, two combinational read ports, one
// synchronous write port; r0 always reads zero and ignores writes.
module nbbpu_regfile
  import nbbpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [FIELD_W-1:0]    ra_addr_i,
  output logic [DATA_WIDTH-1:0] ra_data_o,
  input  logic [FIELD_W-1:0]    rb_addr_i,
  output logic [DATA_WIDTH-1:0] rb_data_o,
  input  logic                  we_i,
  input  logic [FIELD_W-1:0]    wa_i,
  input  logic [DATA_WIDTH-1:0] wd_i
);

  logic [DATA_WIDTH-1:0] regs_q [16];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/nbbpu_mc.sv
// nbbpu_mc: multi-cycle NBBPU core with a single req/ready memory port.
// Define NBBPU_STALL_COUNT_EN to add the stall_count output (cycles spent waiting on mem_ready).
module nbbpu_mc
  import nbbpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic                  retire,
  output logic                  halted
`ifdef NBBPU_STALL_COUNT_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  localparam logic [DATA_WIDTH-1:0] SHIFT_LIM = DATA_WIDTH'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LO_MASK   = DATA_WIDTH'(16'h00FF);
  localparam logic [DATA_WIDTH-1:0] HI_MASK   = DATA_WIDTH'(16'hFF00);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [INSTR_W-1:0]    ir_q;
  logic                  retire_q;
  logic                  halted_q;

  opcode_e               op;
  logic [FIELD_W-1:0]    fx, fy, fz, ra_addr;
  logic [IMM_W-1:0]      imm8;
  logic [DATA_WIDTH-1:0] a_val, y_val, alu_res, wd;
  logic [ADDR_WIDTH-1:0] pc_inc, target, pc_next;
  logic                  taken, halt_hit, we, req_state;

  assign op      = opcode_e'(ir_q[OP_LSB +: FIELD_W]);
  assign fx      = ir_q[X_LSB +: FIELD_W];
  assign fy      = ir_q[Y_LSB +: FIELD_W];
  assign fz      = ir_q[Z_LSB +: FIELD_W];
  assign imm8    = ir_q[IMM_LSB +: IMM_W];
  // SEL/SEU carry an immediate in x/y, so port A reads z to preserve its untouched byte.
  assign ra_addr = (op inside {OP_SEL, OP_SEU}) ? fz : fx;
  assign pc_inc  = pc_q + ADDR_WIDTH'(1);

  nbbpu_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .ra_addr_i (ra_addr),
    .ra_data_o (a_val),
    .rb_addr_i (fy),
    .rb_data_o (y_val),
    .we_i      (we),
    .wa_i      (fz),
    .wd_i      (wd)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = a_val + y_val;
      OP_SUB: alu_res = a_val - y_val;
      OP_AND: alu_res = a_val & y_val;
      OP_IOR: alu_res = a_val | y_val;
      OP_XOR: alu_res = a_val ^ y_val;
      OP_SHR: alu_res = (y_val >= SHIFT_LIM) ? '0 : (a_val >> y_val);
      OP_SHL: alu_res = (y_val >= SHIFT_LIM) ? '0 : (a_val << y_val);
      OP_CMP: alu_res = (a_val > y_val) ? DATA_WIDTH'(1) : ((a_val == y_val) ? '0 : '1);
      OP_JMP: alu_res = DATA_WIDTH'(pc_inc);
      OP_SEL: alu_res = (a_val & ~LO_MASK) | DATA_WIDTH'(imm8);
      OP_SEU: alu_res = (a_val & ~HI_MASK) | DATA_WIDTH'({imm8, 8'h00});
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    target = a_val[ADDR_WIDTH-1:0];
    case (op)
      OP_JMP: taken = 1'b1;
      OP_BRZ: begin
        taken  = (a_val == '0);
        target = y_val[ADDR_WIDTH-1:0];
      end
      OP_BRN: begin
        taken  = a_val[DATA_WIDTH-1];
        target = y_val[ADDR_WIDTH-1:0];
      end
      default: taken = 1'b0;
    endcase
  end

  assign pc_next  = taken ? target : pc_inc;
  assign halt_hit = taken && (target == pc_q);

  assign we = ((state_q == ST_EXECUTE) && writes_reg(op)) ||
              ((state_q == ST_MEMORY) && (op == OP_LOD) && mem_ready);
  assign wd = (state_q == ST_MEMORY) ? mem_rdata : alu_res;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      retire_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        ST_FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata[INSTR_W-1:0];
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          if (is_mem_op(op)) begin
            state_q <= ST_MEMORY;
          end else if (halt_hit) begin
            retire_q <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            retire_q <= 1'b1;
            pc_q     <= pc_next;
            state_q  <= ST_FETCH;
          end
        end
        ST_MEMORY: begin
          if (mem_ready) begin
            retire_q <= 1'b1;
            pc_q     <= pc_inc;
            state_q  <= ST_FETCH;
          end
        end
        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign req_state = (state_q == ST_FETCH) || (state_q == ST_MEMORY);

  // Bus outputs are gated by reset so an in-flight request drops the moment reset rises.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (state_q == ST_FETCH) begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end else if (state_q == ST_MEMORY) begin
        mem_req   = 1'b1;
        mem_we    = (op == OP_STR);
        mem_addr  = a_val[ADDR_WIDTH-1:0];
        mem_wdata = (op == OP_STR) ? y_val : '0;
      end
    end
  end

  assign PC     = pc_q;
  assign retire = retire_q;
  assign halted = halted_q;

`ifdef NBBPU_STALL_COUNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (req_state && !mem_ready && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_nbbpu_mc.sv
// tb_nbbpu_mc: ISA-level reference model feeds an event scoreboard (retire PCs and
// memory writes); a separate monitor compares DUT activity against it.
`timescale 1ns/1ps
module tb_nbbpu_mc;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req, mem_we, retire, halted;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr, PC;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef NBBPU_STALL_COUNT_EN
  logic [31:0]   stall_count;
`endif

  nbbpu_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(16'h0000)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .PC        (PC),
    .retire    (retire),
    .halted    (halted)
`ifdef NBBPU_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_wr;
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] mem     [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] m_regs  [16];
  logic [15:0] m_pc;
  bit          m_halted;
  int          checks = 0;
  int          errors = 0;
  int          n_retire = 0;
  int          wait_mode = 0;
  int          wcnt = 0;
  int          wtarget = 0;
  int unsigned stall_exp = 0;
  bit          prev_wait = 0;
  logic [15:0] sv_addr, sv_wdata;
  logic        sv_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic int pick_wait();
    case (wait_mode)
      0:       return 0;
      1:       return 3;
      2:       return int'($urandom_range(0, 2));
      default: return 10;
    endcase
  endfunction

  // ---------------- reference model: one instruction at the model PC ----------------
  task automatic model_step();
    logic [15:0] ins, xv, yv, zv, res, npc;
    logic [3:0]  op, x, y, z;
    bit          wr;
    if (m_halted) return;
    ins = ref_mem[m_pc];
    op = ins[15:12]; x = ins[11:8]; y = ins[7:4]; z = ins[3:0];
    xv = m_regs[x]; yv = m_regs[y]; zv = m_regs[z];
    npc = m_pc + 16'd1; wr = 1; res = '0;
    case (op)
      4'h0: res = xv + yv;
      4'h1: res = xv - yv;
      4'h2: res = xv & yv;
      4'h3: res = xv | yv;
      4'h4: res = xv ^ yv;
      4'h5: res = (yv >= 16) ? 16'h0 : (xv >> yv);
      4'h6: res = (yv >= 16) ? 16'h0 : (xv << yv);
      4'h7: res = (xv > yv) ? 16'h1 : ((xv == yv) ? 16'h0 : 16'hFFFF);
      4'h8: begin res = m_pc + 16'd1; npc = xv; end
      4'h9: begin wr = 0; if (xv == 0) npc = yv; end
      4'hA: begin wr = 0; if (xv[15]) npc = yv; end
      4'hB: wr = 0;
      4'hC: res = ref_mem[xv];
      4'hD: begin
        wr = 0;
        ref_mem[xv] = yv;
        exp_q.push_back('{1'b1, xv, yv});
      end
      4'hE: res = {zv[15:8], ins[11:4]};
      default: res = {ins[11:4], zv[7:0]};
    endcase
    if (wr && z != 0) m_regs[z] = res;
    if (npc == m_pc) m_halted = 1;   // taken control transfer onto itself
    else m_pc = npc;
    exp_q.push_back('{1'b0, m_pc, 16'h0});
  endtask

  task automatic emit(input logic [15:0] ins);
    mem[m_pc]     = ins;
    ref_mem[m_pc] = ins;
    model_step();
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] x,
                                      input logic [3:0] y, input logic [3:0] z);
    return {op, x, y, z};
  endfunction

  task automatic sel(input logic [3:0] z, input logic [7:0] imm);
    emit({4'hE, imm, z});
  endtask

  task automatic dump_regs();
    for (int i = 1; i < 16; i++) emit(enc(4'hD, 4'h0, 4'(i), 4'h0));
  endtask

  task automatic halt_seq();
    logic [15:0] a;
    a = m_pc + 16'd2;
    sel(4'd15, a[7:0]);
    emit({4'hF, a[15:8], 4'd15});
    emit(enc(4'h8, 4'd15, 4'h0, 4'd14));
  endtask

  // ---------------- memory responder + monitor ----------------
  task automatic pop_cmp(input bit is_wr, input logic [15:0] a, input logic [15:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got %s a=%h d=%h required none", is_wr ? "write" : "retire", a, d);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 32'(is_wr), 32'(e.is_wr));
    if (is_wr) begin
      $display("write [%h] = %h", a, d);
      chk("wr_addr", 32'(a), 32'(e.a));
      chk("wr_data", 32'(d), 32'(e.d));
    end else begin
      $display("retire pc=%h", a);
      chk("retire_pc", 32'(a), 32'(e.a));
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_wait = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end else begin
      if (mem_req) begin
        if (prev_wait) begin
          chk("stable_addr", 32'(mem_addr), 32'(sv_addr));
          chk("stable_we", 32'(mem_we), 32'(sv_we));
          if (sv_we) chk("stable_wdata", 32'(mem_wdata), 32'(sv_wdata));
        end
        mem_ready = (wcnt >= wtarget);
        if (!mem_ready) begin
          wcnt++;
          stall_exp++;
        end
        mem_rdata = mem_ready ? mem[mem_addr] : 16'($urandom);
        prev_wait = !mem_ready;
        sv_addr = mem_addr; sv_we = mem_we; sv_wdata = mem_wdata;
        if (mem_ready && mem_we) pop_cmp(1'b1, mem_addr, mem_wdata);
      end else begin
        prev_wait = 0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = 16'($urandom);
      end
      if (retire) begin
        n_retire++;
        pop_cmp(1'b0, PC, 16'h0);
      end
    end
  end

  always @(posedge clock) begin
    if (!reset && mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      wcnt = 0;
      wtarget = pick_wait();
    end
  end

  // ---------------- test sequencing ----------------
  task automatic start_test(input int mode);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pc = 16'h0; m_halted = 0;
    exp_q.delete();
    n_retire = 0; stall_exp = 0; wcnt = 0;
    wait_mode = mode; wtarget = pick_wait();
    repeat (2) @(negedge clock);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_to_halt(input string name);
    int req_cnt;
    bit done;
    done = 0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clock); #1;
      if (halted) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got halted=%0b required 1", name, halted);
      return;
    end
    chk("halt_flag", 32'(m_halted), 32'(halted));
    chk("halt_pc", 32'(PC), 32'(m_pc));
    req_cnt = 0;
    repeat (20) begin
      @(negedge clock); #1;
      if (mem_req) req_cnt++;
    end
    chk("req_while_halted", 32'(req_cnt), 32'd0);
    chk("still_halted", 32'(halted), 32'd1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef NBBPU_STALL_COUNT_EN
    chk("stall_count", stall_count, 32'(stall_exp));
`endif
    $display("test %s done, retires=%0d", name, n_retire);
  endtask

  task automatic basic_prog();
    sel(4'd1, 8'd5);
    sel(4'd2, 8'd3);
    emit(enc(4'h0, 4'd1, 4'd2, 4'd3));
    emit(enc(4'hD, 4'd0, 4'd3, 4'd0));
    halt_seq();
  endtask

  initial begin
    int cyc;
    logic [3:0]  op, x, y, z;
    logic [15:0] addr;
    bit          hit;

    // reset values
    @(negedge clock); #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_pc", 32'(PC), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // zero-wait basic program: four retires take nine cycles
    start_test(0);
    basic_prog();
    release_reset();
    #1;
    chk("req_first_cycle", 32'(mem_req), 32'd1);
    cyc = 0;
    while (n_retire < 4 && cyc < 100) begin
      @(negedge clock); #1;
      cyc++;
    end
    chk("cycles_for_4_retires", 32'(cyc), 32'd9);
    run_to_halt("zero_wait");
    chk("mem0_sum", 32'(mem[0]), 32'd8);

    // three wait states on every transaction
    start_test(1);
    basic_prog();
    release_reset();
    run_to_halt("wait3");
    chk("mem0_sum_wait", 32'(mem[0]), 32'd8);

    // ALU corners: CMP, SUB underflow, shift limits, SEL/SEU, aliased operands
    start_test(0);
    sel(4'd1, 8'd2);
    sel(4'd2, 8'd7);
    emit(enc(4'h7, 4'd1, 4'd2, 4'd3));
    emit(enc(4'h7, 4'd2, 4'd1, 4'd4));
    emit(enc(4'h7, 4'd1, 4'd1, 4'd5));
    sel(4'd7, 8'd1);
    emit(enc(4'h1, 4'd0, 4'd7, 4'd6));
    sel(4'd8, 8'd16);
    emit(enc(4'h6, 4'd6, 4'd8, 4'd9));
    emit(enc(4'h5, 4'd6, 4'd8, 4'd10));
    emit(enc(4'h6, 4'd6, 4'd7, 4'd11));
    emit(enc(4'h5, 4'd6, 4'd7, 4'd12));
    sel(4'd13, 8'hAB);
    emit({4'hF, 8'hCD, 4'd13});
    sel(4'd13, 8'h12);
    emit(enc(4'h0, 4'd2, 4'd2, 4'd2));
    emit(enc(4'h0, 4'd1, 4'd2, 4'd0));
    dump_regs();
    halt_seq();
    release_reset();
    run_to_halt("alu_corners");

    // control flow: BRZ taken/not taken, JMP link, BRN taken/not taken
    start_test(2);
    sel(4'd1, 8'h20);
    emit(enc(4'h9, 4'd0, 4'd1, 4'd0));
    sel(4'd2, 8'd5);
    emit(enc(4'h9, 4'd2, 4'd1, 4'd0));
    sel(4'd3, 8'h30);
    emit(enc(4'h8, 4'd3, 4'd0, 4'd4));
    sel(4'd5, 8'h00);
    emit({4'hF, 8'h80, 4'd5});
    sel(4'd6, 8'h40);
    emit(enc(4'hA, 4'd5, 4'd6, 4'd0));
    emit(enc(4'hA, 4'd6, 4'd1, 4'd0));
    emit(enc(4'hB, 4'd0, 4'd0, 4'd0));
    dump_regs();
    halt_seq();
    release_reset();
    run_to_halt("control");

    // minimal self-jump halt
    start_test(0);
    sel(4'd1, 8'd1);
    emit(enc(4'h8, 4'd1, 4'd0, 4'd2));
    release_reset();
    run_to_halt("self_jump");
    chk("self_jump_retires", 32'(n_retire), 32'd2);

    // randomized straight-line programs with random wait states
    for (int p = 0; p < 6; p++) begin
      start_test(2);
      for (int k = 0; k < 40; k++) begin
        do op = 4'($urandom_range(0, 15)); while (op inside {4'h8, 4'h9, 4'hA});
        x = 4'($urandom); y = 4'($urandom); z = 4'($urandom);
        if (op == 4'hC || op == 4'hD) begin
          addr = m_regs[x];
          if (addr > m_pc && addr < 16'd128) x = 4'd0;
        end
        emit(enc(op, x, y, z));
      end
      dump_regs();
      halt_seq();
      release_reset();
      run_to_halt("random");
    end

    // reset during a waiting STR: no write lands, restart from clean state
    start_test(3);
    sel(4'd1, 8'h40);
    sel(4'd2, 8'h55);
    emit(enc(4'hD, 4'd1, 4'd2, 4'd0));
    halt_seq();
    release_reset();
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clock); #1;
      if (mem_req && mem_we) hit = 1;
    end
    chk("str_reached", 32'(hit), 32'd1);
    repeat (2) begin
      @(negedge clock); #1;
    end
    chk("str_still_waiting", 32'(mem_req && mem_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("req_drop_on_reset", 32'(mem_req), 32'd0);
    repeat (3) @(negedge clock);
    #1;
    chk("aborted_store", 32'(mem[16'h40]), 32'd0);
    chk("pc_after_abort", 32'(PC), 32'd0);
    chk("retire_after_abort", 32'(retire), 32'd0);
    start_test(0);
    dump_regs();
    halt_seq();
    release_reset();
    run_to_halt("post_reset_dump");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish required finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
